// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program-counter and fetch-control stage feeding the
// instruction memory of the single-cycle RV32I core.
//
// Owns the PC, drives the word-aligned fetch address and hands the fetched
// word to decode with a valid flag. It handles sequential advance,
// branch/jump redirect, stall, halt on a zero word and a trap on a
// misaligned redirect target.
//
// Ports:
//   clk             core clock, rising edge
//   reset           asynchronous, active-high reset
//   stall           hold the PC this cycle
//   redirect_valid  branch taken / jump resolved this cycle
//   redirect_target new PC for the redirect
//   instruction     word returned combinationally by imem for addr
//   addr            fetch address (equals PC, always word aligned)
//   pc_plus4        PC+4, the JAL/JALR link value
//   instr_out       instruction to decode, NOP when not valid
//   instr_valid     instr_out carries a real instruction this cycle
//   halted          fetch stopped (HALT or TRAP)
//   misalign_err    sticky, a redirect target was not word aligned
//   cycle_cnt       (FETCH_PERF_CNT_EN only) cycles spent in RUN
//   fetch_cnt       (FETCH_PERF_CNT_EN only) cycles with instr_valid=1
//
// Optional feature macro: FETCH_PERF_CNT_EN adds the two performance
// counters. Without it the ports and counter logic do not exist.

module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH   = 32,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] instruction,
  output logic [31:0] addr,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] fetch_cnt,
`endif
  output logic        misalign_err
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OFFW = XLEN + 2;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;
  // Byte offset of the last fetchable word from RESET_PC.
  localparam logic [OFFW-1:0] RANGE_SPAN = OFFW'(4 * (IMEM_DEPTH - 1));

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT,
    ST_TRAP
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] pc_inc;
  logic [OFFW-1:0] tgt_off;
  logic [OFFW-1:0] inc_off;
  logic            tgt_in_range;
  logic            inc_in_range;
  logic            zero_word;
  logic            tgt_misaligned;

  // Range check as an offset from RESET_PC, widened so neither the +4 nor
  // the upper bound can wrap; a negative offset shows up in the top bit.
  always_comb begin
    pc_inc         = pc_q + 32'd4;
    tgt_off        = {2'b00, redirect_target} - {2'b00, RESET_PC};
    inc_off        = {2'b00, pc_q} + OFFW'(4) - {2'b00, RESET_PC};
    tgt_in_range   = !tgt_off[OFFW-1] && (tgt_off <= RANGE_SPAN);
    inc_in_range   = !inc_off[OFFW-1] && (inc_off <= RANGE_SPAN);
    zero_word      = HALT_ON_ZERO && (instruction == 32'h0000_0000);
    tgt_misaligned = redirect_target[1:0] != 2'b00;
  end

  // Next-state / next-PC selection; first matching condition wins in RUN.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (redirect_valid && tgt_misaligned) begin
          misalign_d = 1'b1;
          state_d    = ST_TRAP;
        end else if (redirect_valid) begin
          pc_d = redirect_target;
          if (!tgt_in_range) state_d = ST_HALT;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (zero_word) begin
          state_d = ST_HALT;
        end else begin
          pc_d = pc_inc;
          if (!inc_in_range) state_d = ST_HALT;
        end
      end
      default: ;
    endcase
  end

  // State, PC and sticky error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  // Decode-facing outputs are a same-cycle pass-through of the imem word.
  always_comb begin
    instr_valid = (state_q == ST_RUN) && !stall && !zero_word;
    instr_out   = instr_valid ? instruction : NOP_WORD;
  end

  assign addr         = pc_q;
  assign pc_plus4     = pc_inc;
  assign halted       = (state_q == ST_HALT) || (state_q == ST_TRAP);
  assign misalign_err = misalign_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, fetch_cnt_q;

  // Performance counters; they only move in RUN so they freeze once halted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_q <= 32'd0;
      fetch_cnt_q <= 32'd0;
    end else if (state_q == ST_RUN) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (instr_valid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with default parameters
// (RESET_PC=0, IMEM_DEPTH=32, HALT_ON_ZERO=1).
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instruction;
  logic [31:0] addr;
  logic [31:0] pc_plus4;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        halted;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] fetch_cnt;
`endif

  logic [31:0] mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  fetch_pc_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instruction     (instruction),
    .addr            (addr),
    .pc_plus4        (pc_plus4),
    .instr_out       (instr_out),
    .instr_valid     (instr_valid),
    .halted          (halted),
`ifdef FETCH_PERF_CNT_EN
    .cycle_cnt       (cycle_cnt),
    .fetch_cnt       (fetch_cnt),
`endif
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  // Behavioural instruction memory: words outside 0x00..0x7C read as zero.
  assign instruction = (addr < 32'h80) ? mem[addr[6:2]] : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse, reset-value checks, then BOOT edge into RUN at PC 0.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_addr", addr, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_out", instr_out, NOP);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_misalign", 32'(misalign_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("boot_valid", 32'(instr_valid), 32'h0);
    tick();
    check("run0_addr", addr, 32'h0);
    check("run0_valid", 32'(instr_valid), 32'h1);
    check("run0_out", instr_out, mem[0]);
  endtask

  initial begin
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);

    // Sequential fetch from reset.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("seq_addr", addr, 32'(4 * k));
      check("seq_out", instr_out, mem[k]);
    end

    // Stall for three cycles at 0x18.
    stall = 1'b1;
    #1;
    check("stall_valid", 32'(instr_valid), 32'h0);
    check("stall_out", instr_out, NOP);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_addr", addr, 32'h18);
    end
    stall = 1'b0;
    #1;
    check("unstall_out", instr_out, mem[6]);
    tick();
    check("resume_addr", addr, 32'h1C);
    tick();
    tick();
    tick();
    check("pre_redir_addr", addr, 32'h28);

    // Redirect wins over stall.
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h08;
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("redir_addr", addr, 32'h08);
    check("redir_out", instr_out, mem[2]);

    // Run to the top of memory, then the advance past 0x7C halts.
    for (int k = 0; k < 29; k++) tick();
    check("top_addr", addr, 32'h7C);
    check("top_pc4", pc_plus4, 32'h80);
    check("top_halted", 32'(halted), 32'h0);
    tick();
    check("end_addr", addr, 32'h80);
    check("end_halted", 32'(halted), 32'h1);
    check("end_valid", 32'(instr_valid), 32'h0);
    check("end_out", instr_out, NOP);
    tick();
    check("end_frozen", addr, 32'h80);

    // Asynchronous reset mid-run at 0x40.
    do_reset();
    for (int k = 0; k < 16; k++) tick();
    check("pre_async_addr", addr, 32'h40);
    #2;
    reset = 1'b1;
    #1;
    check("async_addr", addr, 32'h0);
    check("async_valid", 32'(instr_valid), 32'h0);
    #1;
    reset = 1'b0;
    #1;
    check("async_boot_valid", 32'(instr_valid), 32'h0);
    tick();
    check("async_run_addr", addr, 32'h0);
    check("async_run_valid", 32'(instr_valid), 32'h1);

    // Misaligned redirect traps with PC held.
    tick();
    tick();
    tick();
    check("pre_trap_addr", addr, 32'h0C);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0006;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("trap_addr", addr, 32'h0C);
      check("trap_misalign", 32'(misalign_err), 32'h1);
      check("trap_halted", 32'(halted), 32'h1);
      check("trap_valid", 32'(instr_valid), 32'h0);
      tick();
    end

    // Aligned redirect outside the fetch range halts at the target.
    do_reset();
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    check("oor_addr", addr, 32'h100);
    check("oor_halted", 32'(halted), 32'h1);
    check("oor_misalign", 32'(misalign_err), 32'h0);

    // Zero word at 0x68 halts with the address frozen there.
    mem[26] = 32'h0;
    do_reset();
    for (int k = 0; k < 26; k++) tick();
    check("zero_addr", addr, 32'h68);
    check("zero_valid", 32'(instr_valid), 32'h0);
    check("zero_out", instr_out, NOP);
    tick();
    check("zero_halt_addr", addr, 32'h68);
    check("zero_halted", 32'(halted), 32'h1);
    tick();
    check("zero_frozen", addr, 32'h68);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and fetch-control stage directly upstream of the instruction memory in the single-cycle RV32I core.
- Owns the PC register and drives the word-aligned fetch address.
- Receives the fetched word back and presents it to decode with a valid flag.
- Handles sequential advance, branch/jump redirect, stall, halt-on-zero-word and misaligned-target trap.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_DEPTH, 32, instruction memory depth in words; fetch range is RESET_PC to RESET_PC+4*IMEM_DEPTH-4.
- HALT_ON_ZERO, 1, when 1 a fetched word of 32'h0000_0000 (unused memory) halts fetch.

Ports:
- clk  input  1  core clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC this cycle.
- redirect_valid  input  1  branch taken or jump resolved this cycle.
- redirect_target  input  32  new PC for the redirect.
- instruction  input  32  word returned combinationally by instruction memory for addr.
- addr  output  32  fetch address to instruction memory; equals PC.
- pc_plus4  output  32  PC+4, used for the JAL/JALR link value.
- instr_out  output  32  instruction to decode; NOP 32'h0000_0013 when not valid.
- instr_valid  output  1  instr_out is a real instruction this cycle.
- halted  output  1  fetch stopped (HALT state).
- misalign_err  output  1  sticky; a redirect target had bits [1:0] != 0.

Behaviour:
- The single clock is clk. Reset is asynchronous and active-high on port reset.
- Reset values:
  - PC = RESET_PC, so addr = RESET_PC and pc_plus4 = RESET_PC+4.
  - instr_valid = 0, instr_out = 32'h0000_0013, halted = 0, misalign_err = 0.
  - state = BOOT.
- FSM states: BOOT, RUN, HALT, TRAP.
- BOOT:
  - Lasts exactly one clk edge after reset deasserts; gives instruction memory time to load.
  - instr_valid = 0. Transitions to RUN. PC is unchanged.
- RUN, decision order each rising edge (first match wins):
  1. redirect_valid=1 with redirect_target[1:0] != 0: PC holds, misalign_err <= 1, go to TRAP.
  2. redirect_valid=1 with aligned target:
     - Target outside the fetch range: PC <= target, go to HALT.
     - Otherwise PC <= redirect_target. This case wins over stall.
  3. stall=1: PC holds, state holds.
  4. HALT_ON_ZERO=1 and instruction == 32'h0000_0000: PC holds, go to HALT.
  5. Otherwise PC <= PC+4, modulo 2^32.
     - If PC+4 leaves the fetch range (including 32-bit wrap), go to HALT with PC <= PC+4.
- RUN outputs, combinational:
  - instr_valid = 1 when stall=0 and the word is not a halting zero word; else 0.
  - instr_out = instruction when instr_valid, else NOP.
- HALT: PC frozen, instr_valid = 0, halted = 1. Exited only by reset.
- TRAP: same as HALT, plus misalign_err = 1. Exited only by reset.
- Latency:
  - addr changes one clk edge after the redirect or advance condition.
  - instr_out follows instruction with zero added cycles (combinational pass-through).
- Range check: PC is in range iff RESET_PC <= PC <= RESET_PC+4*(IMEM_DEPTH-1). Compare with 33-bit arithmetic so the upper bound cannot overflow.
- Reset asserted mid-operation: all state returns immediately (asynchronously) to reset values, with no wait for clk.
- addr[1:0] is always 2'b00 by construction.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- With the macro defined, two extra outputs are added:
  - cycle_cnt[31:0]: increments every clk in RUN.
  - fetch_cnt[31:0]: increments on every cycle with instr_valid=1.
  - Both reset to 0, wrap at 2^32 and freeze in HALT/TRAP.
- Without the macro, the ports and counter logic are absent and the rest of the behaviour is identical.

Test Plan:
- Reset release, memory words nonzero, no stall → 1st edge BOOT (valid=0); then addr steps 0x0, 0x4, 0x8, ..., with instr_out equal to each word and instr_valid=1.
- At PC=0x18 assert stall=1 for 3 cycles → addr held at 0x18, instr_valid=0, instr_out=0x00000013; resumes at 0x1C.
- At PC=0x28 with stall=1, redirect_valid=1, target=0x08 → next addr=0x08 (redirect beats stall).
- Redirect target=0x0000_0006 → PC holds, misalign_err=1, halted=1, instr_valid=0 until reset.
- Word at 0x68 equals 0 (HALT_ON_ZERO=1) → halted=1 with addr frozen at 0x68. Separately, with all words nonzero, the advance from 0x7C → PC=0x80, halted=1.
- Assert reset asynchronously mid-run at PC=0x40 → addr=0x0 and instr_valid=0 immediately, before the next clk edge, then the BOOT sequence repeats.
